// File: rtl/bingo_board_renderer.sv
// Two-stage VGA pixel renderer for an N x N Bingo board: per-frame state snapshot,
// sprite-ROM tile addressing, blinking completed-line strikes and a cursor outline.
module bingo_board_renderer #(
  parameter int          GRID_N       = 5,
  parameter int          CELL_LOG2    = 6,
  parameter int          ORIGIN_X     = 160,
  parameter int          ORIGIN_Y     = 80,
  parameter int          VAL_W        = 5,
  parameter int          BLINK_FRAMES = 30,
  parameter int          LINE_W       = 4,
  parameter logic [11:0] FRAME_RGB    = 12'h732,
  parameter logic [11:0] CIRCLE_RGB   = 12'hC22,
  parameter logic [11:0] LINE_RGB     = 12'hFF0,
  parameter logic [11:0] CURSOR_RGB   = 12'h0F0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pix_en,
  input  logic [9:0]                      h_cnt,
  input  logic [9:0]                      v_cnt,
  input  logic                            valid_in,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic [VAL_W*GRID_N*GRID_N-1:0]  map,
  input  logic [GRID_N*GRID_N-1:0]        circle,
  input  logic [2*GRID_N+1:0]             line,
  input  logic [2:0]                      cursor_x,
  input  logic [2:0]                      cursor_y,
  input  logic                            cursor_en,
  output logic [VAL_W-1:0]                tile_id,
  output logic [CELL_LOG2-1:0]            tile_px,
  output logic [CELL_LOG2-1:0]            tile_py,
  input  logic [11:0]                     tile_rgb,
  input  logic                            circle_mask,
  input  logic [11:0]                     bg_rgb,
  output logic                            hsync,
  output logic                            vsync,
  output logic [11:0]                     vga_rgb
);

  localparam int CELL  = 1 << CELL_LOG2;
  localparam int BOARD = GRID_N * CELL;
  localparam int HW    = LINE_W / 2;
  localparam int NCELL = GRID_N * GRID_N;
  localparam int CI_W  = $clog2(NCELL);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [VAL_W*NCELL-1:0] map_s;
  logic [NCELL-1:0]       circle_s;
  logic [2*GRID_N+1:0]    line_s;
  logic [2:0]             cur_x_s, cur_y_s;
  logic                   cur_en_s;
  logic [CNT_W-1:0]       blink_cnt;
  logic                   blink_on;

  logic s1_valid, s1_hsync, s1_vsync, s1_in_board, s1_border;
  logic s1_strike, s1_cursor, s1_circled;

  logic [VAL_W-1:0] map_cells [NCELL];

  for (genvar i = 0; i < NCELL; i++) begin : g_cells
    assign map_cells[i] = map_s[i*VAL_W +: VAL_W];
  end

  function automatic logic near(input int d);
    return (d < HW) && (d > -HW);
  endfunction

  int                   hi, vi, dx, dy, pxi, pyi;
  logic                 in_board, ring;
  logic [2:0]           bx, by;
  logic [CELL_LOG2-1:0] px, py;
  logic [CI_W-1:0]      cell_lin;
  logic                 row_flag, col_flag, main_hit, anti_hit, strike, cursor_hit;

  assign hi  = int'(h_cnt);
  assign vi  = int'(v_cnt);
  assign dx  = hi - ORIGIN_X;
  assign dy  = vi - ORIGIN_Y;
  assign bx  = 3'(dx >> CELL_LOG2);
  assign by  = 3'(dy >> CELL_LOG2);
  assign px  = CELL_LOG2'(dx);
  assign py  = CELL_LOG2'(dy);
  assign pxi = int'(px);
  assign pyi = int'(py);

  assign in_board = (hi >= ORIGIN_X) && (hi < ORIGIN_X + BOARD) &&
                    (vi >= ORIGIN_Y) && (vi < ORIGIN_Y + BOARD);
  assign ring     = (hi >= ORIGIN_X - 2) && (hi < ORIGIN_X + BOARD + 2) &&
                    (vi >= ORIGIN_Y - 2) && (vi < ORIGIN_Y + BOARD + 2) && !in_board;
  assign cell_lin = in_board ? CI_W'(int'(by) * GRID_N + int'(bx)) : '0;

  // Strike geometry: rows/columns are bands through the cell centre, diagonals follow px==py
  assign row_flag = |(line_s[GRID_N-1:0] & (GRID_N'(1) << by));
  assign col_flag = |(line_s[2*GRID_N-1:GRID_N] & (GRID_N'(1) << bx));
  assign main_hit = line_s[2*GRID_N] && (bx == by) && near(pxi - pyi);
  assign anti_hit = line_s[2*GRID_N+1] && ((int'(bx) + int'(by)) == GRID_N - 1) &&
                    near(pxi + pyi - (CELL - 1));
  assign strike   = blink_on && in_board &&
                    ((row_flag && near(pyi - CELL/2)) || (col_flag && near(pxi - CELL/2)) ||
                     main_hit || anti_hit);

  assign cursor_hit = cur_en_s && in_board && (cur_x_s == bx) && (cur_y_s == by) &&
                      ((pxi <= 1) || (pxi >= CELL - 2) || (pyi <= 1) || (pyi >= CELL - 2));

  // Board state is frozen for the whole frame at the top-left pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      map_s     <= '0;
      circle_s  <= '0;
      line_s    <= '0;
      cur_x_s   <= '0;
      cur_y_s   <= '0;
      cur_en_s  <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0)) begin
      map_s    <= map;
      circle_s <= circle;
      line_s   <= line;
      cur_x_s  <= cursor_x;
      cur_y_s  <= cursor_y;
      cur_en_s <= cursor_en;
      if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_hsync    <= 1'b1;
      s1_vsync    <= 1'b1;
      s1_in_board <= 1'b0;
      s1_border   <= 1'b0;
      s1_strike   <= 1'b0;
      s1_cursor   <= 1'b0;
      s1_circled  <= 1'b0;
      tile_id     <= '0;
      tile_px     <= '0;
      tile_py     <= '0;
    end else if (pix_en) begin
      s1_valid    <= valid_in;
      s1_hsync    <= hsync_in;
      s1_vsync    <= vsync_in;
      s1_in_board <= in_board;
      s1_border   <= ring;
      s1_strike   <= strike;
      s1_cursor   <= cursor_hit;
      s1_circled  <= in_board && circle_s[cell_lin];
      tile_id     <= in_board ? map_cells[cell_lin] : '0;
      tile_px     <= in_board ? px : '0;
      tile_py     <= in_board ? py : '0;
    end
  end

  // ROM data arrives alongside stage-1 state, so colour selection happens here
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_rgb <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else if (pix_en) begin
      hsync <= s1_hsync;
      vsync <= s1_vsync;
      if (!s1_valid)                       vga_rgb <= '0;
      else if (s1_in_board) begin
        if (s1_strike)                     vga_rgb <= LINE_RGB;
        else if (s1_cursor)                vga_rgb <= CURSOR_RGB;
        else if (s1_circled && circle_mask) vga_rgb <= CIRCLE_RGB;
        else if (tile_rgb != 12'h000)      vga_rgb <= tile_rgb;
        else                               vga_rgb <= bg_rgb;
      end
      else if (s1_border)                  vga_rgb <= FRAME_RGB;
      else                                 vga_rgb <= bg_rgb;
    end
  end

endmodule

// File: tb/tb_bingo_board_renderer.sv
// Directed bench for bingo_board_renderer: reset, tile fetch, circles, blink,
// strikes, cursor, border and pipeline freeze, with hand-computed expected colours.
module tb_bingo_board_renderer;

  localparam int GRID_N = 5;
  localparam int VAL_W  = 5;

  logic        clk, rst, pix_en;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid_in, hsync_in, vsync_in;
  logic [VAL_W*GRID_N*GRID_N-1:0] map;
  logic [GRID_N*GRID_N-1:0]       circle;
  logic [2*GRID_N+1:0]            line;
  logic [2:0]  cursor_x, cursor_y;
  logic        cursor_en;
  logic [4:0]  tile_id;
  logic [5:0]  tile_px, tile_py;
  logic [11:0] tile_rgb, bg_rgb, vga_rgb;
  logic        circle_mask, hsync, vsync;

  int vecCount = 0;
  int errCount = 0;
  int frames   = 0;

  bingo_board_renderer dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid_in(valid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .map(map), .circle(circle), .line(line),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .tile_id(tile_id), .tile_px(tile_px), .tile_py(tile_py),
    .tile_rgb(tile_rgb), .circle_mask(circle_mask), .bg_rgb(bg_rgb),
    .hsync(hsync), .vsync(vsync), .vga_rgb(vga_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel-rate strobe; outputs are sampled 1 ns after the edge
  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input logic vld);
    h_cnt = h; v_cnt = v; valid_in = vld; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
  endtask

  task automatic snapshot();
    applyStimulus(10'd0, 10'd0, 1'b0);
    frames++;
  endtask

  function automatic logic phaseOn(input int n);
    return ((n / 30) % 2) == 0;
  endfunction

  task automatic snapOn();
    snapshot();
    for (int i = 0; i < 40 && !phaseOn(frames); i++) snapshot();
  endtask

  task automatic checkPix(input string tag, input logic [9:0] h, input logic [9:0] v,
                          input logic vld, input logic [31:0] exp);
    applyStimulus(h, v, vld);
    applyStimulus(10'd1, 10'd1, 1'b0);
    checkOutput(tag, 32'(vga_rgb), exp);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; pix_en = 1'b0; h_cnt = '0; v_cnt = '0; valid_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; map = '0; circle = '0; line = '0;
    cursor_x = '0; cursor_y = '0; cursor_en = 1'b0;
    tile_rgb = 12'h000; circle_mask = 1'b0; bg_rgb = 12'h0AB;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hsync", 32'(hsync), 'h1);
    checkOutput("rst_vsync", 32'(vsync), 'h1);
    checkOutput("rst_rgb", 32'(vga_rgb), 'h0);
    checkOutput("rst_tile", 32'(tile_id), 'h0);
    rst = 1'b0;

    hsync_in = 1'b0;
    applyStimulus(10'd200, 10'd100, 1'b1);
    checkOutput("sync_lat1", 32'(hsync), 'h1);
    checkOutput("black_after_rst", 32'(vga_rgb), 'h0);
    hsync_in = 1'b1;
    applyStimulus(10'd200, 10'd100, 1'b1);
    checkOutput("sync_lat2", 32'(hsync), 'h0);
    checkOutput("first_px", 32'(vga_rgb), 32'(bg_rgb));
    applyStimulus(10'd200, 10'd100, 1'b1);
    checkOutput("third_px", 32'(vga_rgb), 32'(bg_rgb));
    checkOutput("sync_lat3", 32'(hsync), 'h1);

    map[0 +: 5] = 5'd7;
    map[8*5 +: 5] = 5'd19;
    snapshot();
    applyStimulus(10'd160, 10'd80, 1'b1);
    checkOutput("tile_id00", 32'(tile_id), 'h7);
    checkOutput("tile_px00", 32'(tile_px), 'h0);
    checkOutput("tile_py00", 32'(tile_py), 'h0);
    applyStimulus(10'd357, 10'd153, 1'b1);
    checkOutput("tile_id31", 32'(tile_id), 'd19);
    checkOutput("tile_px31", 32'(tile_px), 'd5);
    checkOutput("tile_py31", 32'(tile_py), 'd9);
    applyStimulus(10'd100, 10'd100, 1'b1);
    checkOutput("tile_out", 32'(tile_id), 'h0);

    tile_rgb = 12'h123;
    checkPix("tile_rgb", 10'd160, 10'd80, 1'b1, 'h123);
    tile_rgb = 12'h000;
    checkPix("tile_transp", 10'd160, 10'd80, 1'b1, 32'(bg_rgb));

    tile_rgb = 12'h123;
    applyStimulus(10'd160, 10'd80, 1'b1);
    applyStimulus(10'd357, 10'd153, 1'b1);
    h_cnt = 10'd160; v_cnt = 10'd80; tile_rgb = 12'h456;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("freeze_rgb", 32'(vga_rgb), 'h123);
    checkOutput("freeze_tile", 32'(tile_id), 'd19);
    applyStimulus(10'd1, 10'd1, 1'b0);
    checkOutput("unfreeze_rgb", 32'(vga_rgb), 'h456);

    tile_rgb = 12'h123; circle[0] = 1'b1; circle_mask = 1'b1;
    snapshot();
    checkPix("circle", 10'd170, 10'd90, 1'b1, 'hC22);
    circle[0] = 1'b0;
    checkPix("circle_midframe", 10'd170, 10'd90, 1'b1, 'hC22);
    snapshot();
    checkPix("circle_cleared", 10'd170, 10'd90, 1'b1, 'h123);
    circle_mask = 1'b0; tile_rgb = 12'h000;

    line[0] = 1'b1;
    snapshot();
    for (int i = 0; i < 62; i++) begin
      checkPix("blink", 10'd200, 10'd112, 1'b1, phaseOn(frames) ? 'hFF0 : 32'(bg_rgb));
      snapshot();
    end
    if (!phaseOn(frames)) snapOn();
    checkPix("row_py31", 10'd200, 10'd111, 1'b1, 'hFF0);
    checkPix("row_py34", 10'd200, 10'd114, 1'b1, 32'(bg_rgb));
    checkPix("row_py30", 10'd200, 10'd110, 1'b1, 32'(bg_rgb));

    line = '0; line[8] = 1'b1; line[10] = 1'b1; line[11] = 1'b1;
    snapOn();
    checkPix("col3", 10'd384, 10'd100, 1'b1, 'hFF0);
    checkPix("diag_hit", 10'd298, 10'd219, 1'b1, 'hFF0);
    checkPix("diag_miss", 10'd298, 10'd228, 1'b1, 32'(bg_rgb));
    checkPix("diag_offcell", 10'd298, 10'd154, 1'b1, 32'(bg_rgb));
    checkPix("anti_hit", 10'd254, 10'd305, 1'b1, 'hFF0);
    checkPix("anti_miss", 10'd254, 10'd312, 1'b1, 32'(bg_rgb));

    line = '0; cursor_en = 1'b1; cursor_x = 3'd1; cursor_y = 3'd3;
    snapshot();
    checkPix("cursor_px0", 10'd224, 10'd292, 1'b1, 'h0F0);
    checkPix("cursor_inner", 10'd229, 10'd277, 1'b1, 32'(bg_rgb));
    checkPix("cursor_py63", 10'd240, 10'd335, 1'b1, 'h0F0);
    checkPix("cursor_othercell", 10'd288, 10'd292, 1'b1, 32'(bg_rgb));
    line[3] = 1'b1;
    snapOn();
    checkPix("strike_over_cursor", 10'd224, 10'd304, 1'b1, 'hFF0);
    line = '0; cursor_x = 3'd6;
    snapshot();
    checkPix("cursor_x6_a", 10'd224, 10'd292, 1'b1, 32'(bg_rgb));
    checkPix("cursor_x6_b", 10'd416, 10'd292, 1'b1, 32'(bg_rgb));

    checkPix("border_158", 10'd158, 10'd200, 1'b1, 'h732);
    checkPix("border_159", 10'd159, 10'd200, 1'b1, 'h732);
    checkPix("border_157", 10'd157, 10'd200, 1'b1, 32'(bg_rgb));
    checkPix("outside_100", 10'd100, 10'd200, 1'b1, 32'(bg_rgb));
    checkPix("border_481", 10'd481, 10'd200, 1'b1, 'h732);
    checkPix("border_482", 10'd482, 10'd200, 1'b1, 32'(bg_rgb));
    checkPix("border_top", 10'd300, 10'd78, 1'b1, 'h732);
    checkPix("border_bot", 10'd300, 10'd401, 1'b1, 'h732);
    checkPix("border_corner", 10'd158, 10'd78, 1'b1, 'h732);
    checkPix("border_novalid", 10'd158, 10'd200, 1'b0, 'h0);
    checkPix("board_novalid", 10'd200, 10'd100, 1'b0, 'h0);

    tile_rgb = 12'h123;
    applyStimulus(10'd160, 10'd80, 1'b1);
    applyStimulus(10'd160, 10'd80, 1'b1);
    checkOutput("pre_rst_rgb", 32'(vga_rgb), 'h123);
    rst = 1'b1; pix_en = 1'b1; hsync_in = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_rgb", 32'(vga_rgb), 'h0);
    checkOutput("midrst_tile", 32'(tile_id), 'h0);
    checkOutput("midrst_hsync", 32'(hsync), 'h1);
    rst = 1'b0; pix_en = 1'b0; hsync_in = 1'b1; frames = 0;
    applyStimulus(10'd160, 10'd80, 1'b1);
    checkOutput("postrst_rgb", 32'(vga_rgb), 'h0);
    checkOutput("postrst_snap", 32'(tile_id), 'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
